// File: rtl/uart_axil_regs.sv
// AXI4-Lite register front end for a UART: TX/RX byte FIFOs, status, control and a registered interrupt.
// Define UART_AXIL_WSTRB_EN to make TX_DATA and CTRL writes depend on wstrb[0].
module uart_axil_regs #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic        chipset_clk,
   input  logic        chipset_rst_n,
   input  logic [12:0] uart_axi_awaddr,
   input  logic        uart_axi_awvalid,
   output logic        uart_axi_awready,
   input  logic [31:0] uart_axi_wdata,
   input  logic [3:0]  uart_axi_wstrb,
   input  logic        uart_axi_wvalid,
   output logic        uart_axi_wready,
   output logic [1:0]  uart_axi_bresp,
   output logic        uart_axi_bvalid,
   input  logic        uart_axi_bready,
   input  logic [12:0] uart_axi_araddr,
   input  logic        uart_axi_arvalid,
   output logic        uart_axi_arready,
   output logic [31:0] uart_axi_rdata,
   output logic [1:0]  uart_axi_rresp,
   output logic        uart_axi_rvalid,
   input  logic        uart_axi_rready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        uart_irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [7:0]    tx_mem_q [FIFO_DEPTH];
   logic [7:0]    rx_mem_q [FIFO_DEPTH];
   logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          irq_en_q, irq_en_d, rx_ovr_q, rx_ovr_d, irq_q, irq_d;

   logic wr_fire_s, rd_fire_s, werr_s, rerr_s, wr_ok_s, rd_ok_s, strb_ok_s;
   logic tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
   logic tx_push_s, tx_pop_s, rx_push_s, rx_pop_s, tx_clr_s, rx_clr_s;
   logic ctrl_wr_s, status_rd_s, ovr_set_s, unused_s;
   logic [7:0]  tx_head_s, rx_head_s;
   logic [31:0] status_s, rd_val_s;

`ifdef UART_AXIL_WSTRB_EN
   assign strb_ok_s = uart_axi_wstrb[0];
`else
   assign strb_ok_s = 1'b1;
`endif
   assign unused_s = ^{uart_axi_wdata[31:8], uart_axi_wstrb};

   assign wr_fire_s = chipset_rst_n & uart_axi_awvalid & uart_axi_wvalid & ~bvalid_q;
   assign rd_fire_s = chipset_rst_n & uart_axi_arvalid & ~rvalid_q;
   assign werr_s    = (|uart_axi_awaddr[12:4]) | (|uart_axi_awaddr[1:0]);
   assign rerr_s    = (|uart_axi_araddr[12:4]) | (|uart_axi_araddr[1:0]);
   assign wr_ok_s   = wr_fire_s & ~werr_s;
   assign rd_ok_s   = rd_fire_s & ~rerr_s;

   // Full: pointer MSBs differ while the index bits match.
   assign tx_empty_s = (tx_wp_q == tx_rp_q);
   assign tx_full_s  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
   assign rx_empty_s = (rx_wp_q == rx_rp_q);
   assign rx_full_s  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
   assign tx_head_s  = tx_mem_q[tx_rp_q[AW-1:0]];
   assign rx_head_s  = rx_mem_q[rx_rp_q[AW-1:0]];

   assign ctrl_wr_s   = wr_ok_s & (uart_axi_awaddr[3:2] == 2'd3) & strb_ok_s;
   assign tx_clr_s    = ctrl_wr_s & uart_axi_wdata[0];
   assign rx_clr_s    = ctrl_wr_s & uart_axi_wdata[1];
   assign tx_pop_s    = ~tx_empty_s & tx_ready;
   assign tx_push_s   = wr_ok_s & (uart_axi_awaddr[3:2] == 2'd1) & strb_ok_s & (~tx_full_s | tx_pop_s);
   assign rx_pop_s    = rd_ok_s & (uart_axi_araddr[3:2] == 2'd0) & ~rx_empty_s;
   assign rx_push_s   = rx_valid & (~rx_full_s | rx_pop_s);
   assign ovr_set_s   = rx_valid & rx_full_s & ~rx_pop_s;
   assign status_rd_s = rd_ok_s & (uart_axi_araddr[3:2] == 2'd2);
   assign status_s    = {26'd0, rx_ovr_q, irq_en_q, tx_full_s, tx_empty_s, rx_full_s, ~rx_empty_s};

   // Read data mux, sampled into rdata_q on the accept edge.
   always_comb begin
      rd_val_s = 32'd0;
      case (uart_axi_araddr[3:2])
         2'd0:    rd_val_s = rx_empty_s ? 32'd0 : {24'd0, rx_head_s};
         2'd1:    rd_val_s = 32'd0;
         2'd2:    rd_val_s = status_s;
         2'd3:    rd_val_s = {27'd0, irq_en_q, 4'd0};
         default: rd_val_s = 32'd0;
      endcase
   end

   // Next-state for pointers, handshakes, control and interrupt.
   always_comb begin
      if (tx_clr_s) begin
         tx_wp_d = '0;
         tx_rp_d = '0;
      end else begin
         tx_wp_d = tx_push_s ? tx_wp_q + PTR_ONE : tx_wp_q;
         tx_rp_d = tx_pop_s  ? tx_rp_q + PTR_ONE : tx_rp_q;
      end
      if (rx_clr_s) begin
         rx_wp_d  = '0;
         rx_rp_d  = '0;
         rx_ovr_d = rx_ovr_q;
      end else begin
         rx_wp_d  = rx_push_s ? rx_wp_q + PTR_ONE : rx_wp_q;
         rx_rp_d  = rx_pop_s  ? rx_rp_q + PTR_ONE : rx_rp_q;
         rx_ovr_d = ovr_set_s ? 1'b1 : (status_rd_s ? 1'b0 : rx_ovr_q);
      end
      bvalid_d = wr_fire_s | (bvalid_q & ~uart_axi_bready);
      bresp_d  = wr_fire_s ? (werr_s ? 2'b10 : 2'b00) : bresp_q;
      rvalid_d = rd_fire_s | (rvalid_q & ~uart_axi_rready);
      rresp_d  = rd_fire_s ? (rerr_s ? 2'b10 : 2'b00) : rresp_q;
      rdata_d  = rd_fire_s ? (rerr_s ? 32'd0 : rd_val_s) : rdata_q;
      irq_en_d = ctrl_wr_s ? uart_axi_wdata[4] : irq_en_q;
      irq_d    = irq_en_q & (~rx_empty_s | rx_ovr_q);
   end

   // State registers with synchronous reset.
   always_ff @(posedge chipset_clk) begin
      if (!chipset_rst_n) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_ovr_q <= 1'b0;
         bvalid_q <= 1'b0;
         bresp_q  <= 2'b00;
         rvalid_q <= 1'b0;
         rresp_q  <= 2'b00;
         rdata_q  <= 32'd0;
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         tx_wp_q  <= tx_wp_d;
         tx_rp_q  <= tx_rp_d;
         rx_wp_q  <= rx_wp_d;
         rx_rp_q  <= rx_rp_d;
         rx_ovr_q <= rx_ovr_d;
         bvalid_q <= bvalid_d;
         bresp_q  <= bresp_d;
         rvalid_q <= rvalid_d;
         rresp_q  <= rresp_d;
         rdata_q  <= rdata_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   // FIFO storage; contents are don't-care while the pointers mark them empty.
   always_ff @(posedge chipset_clk) begin
      if (tx_push_s && !tx_clr_s) begin
         tx_mem_q[tx_wp_q[AW-1:0]] <= uart_axi_wdata[7:0];
      end
      if (rx_push_s && !rx_clr_s) begin
         rx_mem_q[rx_wp_q[AW-1:0]] <= rx_data;
      end
   end

   assign uart_axi_awready = wr_fire_s;
   assign uart_axi_wready  = wr_fire_s;
   assign uart_axi_arready = rd_fire_s;
   assign uart_axi_bvalid  = bvalid_q;
   assign uart_axi_bresp   = bresp_q;
   assign uart_axi_rvalid  = rvalid_q;
   assign uart_axi_rresp   = rresp_q;
   assign uart_axi_rdata   = rdata_q;
   assign tx_valid         = ~tx_empty_s;
   assign tx_data          = tx_empty_s ? 8'h00 : tx_head_s;
   assign uart_irq         = irq_q;
endmodule

// File: tb/tb_uart_axil_regs.sv
// Directed bench for uart_axil_regs: register map, FIFOs, overrun, interrupt, backpressure and reset abort.
module tb_uart_axil_regs;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [12:0] awaddr, araddr;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic [7:0]  tx_data, rx_data;
   logic        tx_valid, tx_ready, rx_valid, uart_irq;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   uart_axil_regs #(.FIFO_DEPTH(16)) dut (
      .chipset_clk(clk), .chipset_rst_n(rst_n),
      .uart_axi_awaddr(awaddr), .uart_axi_awvalid(awvalid), .uart_axi_awready(awready),
      .uart_axi_wdata(wdata), .uart_axi_wstrb(wstrb), .uart_axi_wvalid(wvalid), .uart_axi_wready(wready),
      .uart_axi_bresp(bresp), .uart_axi_bvalid(bvalid), .uart_axi_bready(bready),
      .uart_axi_araddr(araddr), .uart_axi_arvalid(arvalid), .uart_axi_arready(arready),
      .uart_axi_rdata(rdata), .uart_axi_rresp(rresp), .uart_axi_rvalid(rvalid), .uart_axi_rready(rready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .uart_irq(uart_irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [12:0] a, input logic [31:0] d, output logic [1:0] resp);
      int n;
      @(posedge clk); #1;
      awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      n = 0;
      @(negedge clk);
      while (!awready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("aw_w_accept", {31'd0, awready & wready}, 32'd1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      @(negedge clk);
      check("bvalid", {31'd0, bvalid}, 32'd1);
      resp = bresp;
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [12:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      @(posedge clk); #1;
      araddr = a; arvalid = 1'b1; rready = 1'b0;
      n = 0;
      @(negedge clk);
      while (!arready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ar_accept", {31'd0, arready}, 32'd1);
      @(posedge clk); #1;
      arvalid = 1'b0; rready = 1'b1;
      @(negedge clk);
      check("rvalid", {31'd0, rvalid}, 32'd1);
      d = rdata;
      resp = rresp;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   task automatic rx_push(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data = b; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      int          ar_cnt, aw_cnt;
      rst_n = 1'b0; awaddr = 13'd0; araddr = 13'd0; awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b0; arvalid = 1'b0; rready = 1'b0; wdata = 32'd0; wstrb = 4'd0;
      tx_ready = 1'b0; rx_data = 8'd0; rx_valid = 1'b0;

      // Reset for three cycles, then everything must be idle.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ctl", {22'd0, awready, wready, bvalid, bresp, arready, rvalid, rresp, tx_valid, uart_irq}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_txdata", {24'd0, tx_data}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ctl", {22'd0, awready, wready, bvalid, bresp, arready, rvalid, rresp, tx_valid, uart_irq}, 32'd0);
      axi_read(13'h8, d, r);
      check("status_reset", d, 32'h0000_0004);

      // TX push then drain.
      axi_write(13'h4, 32'h41, r);
      check("tx_bresp", {30'd0, r}, 32'd0);
      @(negedge clk);
      check("tx_valid_1", {31'd0, tx_valid}, 32'd1);
      check("tx_data_41", {24'd0, tx_data}, 32'h41);
      @(posedge clk); #1 tx_ready = 1'b1;
      @(posedge clk); #1 tx_ready = 1'b0;
      @(negedge clk);
      check("tx_valid_0", {31'd0, tx_valid}, 32'd0);

      // Keep one TX byte parked, overfill RX by one.
      axi_write(13'h4, 32'h55, r);
      @(posedge clk); #1 rx_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         rx_data = 8'(i);
         @(posedge clk); #1;
      end
      rx_valid = 1'b0;
      axi_read(13'h8, d, r);
      check("status_full_ovr", d, 32'h0000_0023);
      for (int i = 0; i < 16; i++) begin
         axi_read(13'h0, d, r);
         check("rx_byte", d, 32'(i));
      end
      axi_read(13'h0, d, r);
      check("rx_empty_read", d, 32'd0);
      check("rx_empty_rresp", {30'd0, r}, 32'd0);
      axi_read(13'h8, d, r);
      check("status_ovr_cleared", d, 32'h0000_0000);
      @(negedge clk);
      check("tx_parked", {24'd0, tx_data}, 32'h55);
      @(posedge clk); #1 tx_ready = 1'b1;
      @(posedge clk); #1 tx_ready = 1'b0;

      // Decode errors.
      axi_read(13'h10, d, r);
      check("slverr_rresp", {30'd0, r}, 32'd2);
      check("slverr_rdata", d, 32'd0);
      axi_write(13'h1FF4, 32'h41, r);
      check("slverr_bresp", {30'd0, r}, 32'd2);
      axi_read(13'h8, d, r);
      check("status_after_err", d, 32'h0000_0004);
      axi_read(13'hC, d, r);
      check("ctrl_after_err", d, 32'd0);

      // Interrupt enable and RX clear.
      axi_write(13'hC, 32'h10, r);
      axi_read(13'hC, d, r);
      check("ctrl_irq_en", d, 32'h10);
      @(posedge clk); #1 rx_data = 8'h3C; rx_valid = 1'b1;
      @(posedge clk); #1 rx_valid = 1'b0;
      @(negedge clk);
      check("irq_lag", {31'd0, uart_irq}, 32'd0);
      @(negedge clk);
      check("irq_set", {31'd0, uart_irq}, 32'd1);
      axi_write(13'hC, 32'h12, r);
      @(negedge clk);
      check("irq_clr", {31'd0, uart_irq}, 32'd0);
      axi_read(13'h8, d, r);
      check("status_rx_cleared", d, 32'h0000_0014);

      // Backpressure on both channels at once.
      rx_push(8'hA5);
      @(posedge clk); #1;
      araddr = 13'h0; arvalid = 1'b1; rready = 1'b0;
      awaddr = 13'h4; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      ar_cnt = 0; aw_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (arready) ar_cnt++;
         if (awready) aw_cnt++;
         if (i >= 1) check("rdata_hold", rdata, 32'hA5);
      end
      check("ar_once", 32'(ar_cnt), 32'd1);
      check("aw_once", 32'(aw_cnt), 32'd1);
      check("bvalid_hold", {31'd0, bvalid}, 32'd1);
      check("rvalid_hold", {31'd0, rvalid}, 32'd1);
      @(posedge clk); #1;
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b1; bready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0; bready = 1'b0;
      @(negedge clk);
      check("resp_done", {30'd0, rvalid, bvalid}, 32'd0);
      check("tx_77", {24'd0, tx_data}, 32'h77);

      // Reset in the middle of a write response.
      @(posedge clk); #1;
      awaddr = 13'h4; wdata = 32'h99; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      check("pre_rst_bvalid", {31'd0, bvalid}, 32'd1);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("abort_bvalid", {31'd0, bvalid}, 32'd0);
      check("abort_tx_lost", {31'd0, tx_valid}, 32'd0);
      axi_read(13'h8, d, r);
      check("abort_status", d, 32'h0000_0004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/uart_axil_regs.md
UART_AXIL_REGS -- requirements
Module: uart_axil_regs

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning entries per TX/RX FIFO; must be a power of two, at least 2.
REQ-002 SHALL have port chipset_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port chipset_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have AXI4-Lite responder ports, each direction as seen by this block:
- inputs: uart_axi_awaddr [12:0], uart_axi_awvalid, uart_axi_wdata [31:0], uart_axi_wstrb [3:0], uart_axi_wvalid, uart_axi_bready, uart_axi_araddr [12:0], uart_axi_arvalid, uart_axi_rready.
- outputs: uart_axi_awready, uart_axi_wready, uart_axi_bresp [1:0], uart_axi_bvalid, uart_axi_arready, uart_axi_rdata [31:0], uart_axi_rresp [1:0], uart_axi_rvalid.
REQ-005 SHALL have byte-stream ports:
- tx_data output [7:0], tx_valid output 1, tx_ready input 1: bytes to the serializer.
- rx_data input [7:0], rx_valid input 1: bytes from the deserializer; there is no backpressure.
REQ-006 SHALL have port uart_irq, output, 1 bit: the interrupt request, registered.

Function
REQ-007 SHALL use this register map, decoded on addr[3:2]:
- 0x0 RX_DATA (R): a read pops the RX FIFO and returns {24'b0, byte}; if the FIFO is empty, the read returns 0 and nothing is popped.
- 0x4 TX_DATA (W): a write pushes wdata[7:0]; if the TX FIFO is full, the write is dropped.
- 0x8 STATUS (R): bit0 rx_not_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 irq_en, bit5 rx_overrun; all other bits are 0.
- 0xC CTRL (W): bit0 clears the TX FIFO, bit1 clears the RX FIFO, bit4 sets irq_en. Bits 0 and 1 are self-clearing.
- A read of 0xC returns {27'b0, irq_en, 4'b0}.
- A write to 0x0 or 0x8 is ignored and returns OKAY.
REQ-008 SHALL respond SLVERR (2'b10) with no side effects when addr[12:4] is nonzero or addr[1:0] is nonzero; all other accesses return OKAY (2'b00).
REQ-009 Write channel:
- awready and wready SHALL both pulse high for exactly one cycle, in the cycle when awvalid and wvalid are both high and bvalid is low.
- The register effect SHALL occur on that same edge.
- bvalid SHALL rise on the next cycle and hold until bready is sampled high.
REQ-010 Read channel:
- arready SHALL pulse for one cycle when arvalid is high and rvalid is low.
- rdata and rresp SHALL be captured on that edge, with rvalid rising the next cycle.
- rdata, rresp and rvalid SHALL hold stable until rready is sampled high.
REQ-011 The read and write channels SHALL be independent; both may complete in the same cycle.
REQ-012 Throughput SHALL be at most one transaction per 2 cycles per channel. The responder SHALL NOT accept AW without W, or W without AW.
REQ-013 TX side:
- tx_valid SHALL equal tx_not_empty, and tx_data SHALL be the FIFO head.
- A pop occurs on tx_valid and tx_ready.
- A push and a pop in the same cycle leave the count unchanged; when the FIFO is full, a pop plus a push is accepted.
REQ-014 RX side:
- A push occurs on rx_valid.
- A push while the FIFO is full drops the byte and sets rx_overrun, unless an RX_DATA pop occurs in the same cycle, in which case both happen.
REQ-015 rx_overrun SHALL clear on a STATUS read. If a new overrun occurs in the same cycle as the STATUS read, set wins.
REQ-016 A CTRL FIFO clear SHALL take priority over a push or pop in the same cycle: the FIFO ends empty and rx_overrun is unchanged.
REQ-017 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH. Full is defined as MSBs differing with the lower bits equal.
REQ-018 uart_irq SHALL be registered as irq_en AND (rx_not_empty OR rx_overrun), and update one cycle after its inputs change.

Reset
REQ-019 While chipset_rst_n is sampled low:
- all ready and valid outputs, bresp, rresp, rdata, tx_data and uart_irq SHALL be 0;
- both FIFOs SHALL be empty;
- irq_en and rx_overrun SHALL be 0.
REQ-020 A reset asserted mid-transaction SHALL abort it: no B or R response is produced after reset, and the FIFO contents are lost.

Configuration
REQ-021 When macro UART_AXIL_WSTRB_EN is defined:
- a TX_DATA push requires wstrb[0];
- a CTRL update requires wstrb[0];
- a write with wstrb[0]=0 has no effect but still returns OKAY.
When the macro is undefined, wstrb SHALL be ignored.

Verification
REQ-022 Reset low for 3 cycles, then high -> every output is 0; a STATUS read returns 0x00000004.
REQ-023 Write 0x41 to 0x4 with tx_ready=0 -> one awready/wready pulse, then bvalid with resp 0; tx_valid=1 and tx_data=0x41. Then tx_ready=1 for one cycle -> tx_valid=0.
REQ-024 Push 17 RX bytes 0x00..0x10 with FIFO_DEPTH=16 -> STATUS=0x23. Read RX_DATA 16 times -> 0x00..0x0F, then 0 on the 17th. After the STATUS read, rx_overrun=0.
REQ-025 Read 0x10, then write 0x1FF4 -> rresp=2'b10 and bresp=2'b10; the FIFOs and CTRL are unchanged.
REQ-026 Write CTRL=0x10, then push one RX byte -> uart_irq=1 one cycle after the push. Write CTRL=0x12 -> RX empty, and uart_irq=0 one cycle later.
REQ-027 Hold rready=0 and bready=0 for 5 cycles while arvalid and awvalid stay asserted -> no second arready/awready, and rdata stays stable.
